// File: rtl/assoc_cache_control_pkg.sv
// lc3b_types: shared way encodings for the cache controller and its datapath.
package lc3b_types;
    typedef logic [1:0] lc3b_way;
    typedef logic [3:0] lc3b_way_mask;
endpackage

// File: rtl/assoc_cache_control_if.sv
// assoc_cache_control_if: CPU, datapath, LRU-stack and pmem signals of the cache controller.
interface assoc_cache_control_if;
    import lc3b_types::*;
    logic mem_read, mem_write, mem_resp;
    lc3b_way_mask way_hit, way_valid, way_dirty;
    lc3b_way lru, lru_index, way_sel;
    logic lru_write, load_word, load_line;
    logic pmem_addr_sel, pmem_read, pmem_write, pmem_resp;
    modport master (
        input  mem_read, mem_write, way_hit, way_valid, way_dirty, lru, pmem_resp,
        output mem_resp, lru_write, lru_index, way_sel, load_word, load_line,
               pmem_addr_sel, pmem_read, pmem_write
    );
    modport slave (
        output mem_read, mem_write, way_hit, way_valid, way_dirty, lru, pmem_resp,
        input  mem_resp, lru_write, lru_index, way_sel, load_word, load_line,
               pmem_addr_sel, pmem_read, pmem_write
    );
endinterface

// File: rtl/assoc_cache_control_way_select.sv
// way_select: lowest-index hit encoder and victim choice (first invalid way, else LRU).
module way_select
    import lc3b_types::*;
(
    input  lc3b_way_mask hit_mask,
    input  lc3b_way_mask valid_mask,
    input  lc3b_way      lru,
    output logic         hit,
    output lc3b_way      hit_way,
    output lc3b_way      victim
);
    always_comb begin
        hit     = |hit_mask;
        hit_way = hit_mask[0] ? 2'd0 : hit_mask[1] ? 2'd1 : hit_mask[2] ? 2'd2 : 2'd3;
        victim  = !valid_mask[0] ? 2'd0 : !valid_mask[1] ? 2'd1 :
                  !valid_mask[2] ? 2'd2 : !valid_mask[3] ? 2'd3 : lru;
    end
endmodule

// File: rtl/assoc_cache_control.sv
// assoc_cache_control: hit service, dirty writeback and line fill sequencing for the 4-way cache.
module assoc_cache_control
    import lc3b_types::*;
(
    input logic                   clk,
    input logic                   rst_n,
    assoc_cache_control_if.master bus
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;
    state_t  state_q, state_d;
    lc3b_way victim_q, victim_d, hit_way, victim;
    logic    hit, req;
    way_select u_sel (
        .hit_mask(bus.way_hit),
        .valid_mask(bus.way_valid),
        .lru(bus.lru),
        .hit(hit),
        .hit_way(hit_way),
        .victim(victim)
    );
    assign req = bus.mem_read | bus.mem_write;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end
    // IDLE is Mealy on request/hit; the miss states are Moore apart from load_line.
    always_comb begin
        state_d           = state_q;
        victim_d          = victim_q;
        bus.mem_resp      = 1'b0;
        bus.lru_write     = 1'b0;
        bus.lru_index     = 2'd0;
        bus.way_sel       = 2'd0;
        bus.load_word     = 1'b0;
        bus.load_line     = 1'b0;
        bus.pmem_addr_sel = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    bus.mem_resp  = 1'b1;
                    bus.lru_write = 1'b1;
                    bus.lru_index = hit_way;
                    bus.way_sel   = hit_way;
                    bus.load_word = bus.mem_write;
                end else if (req) begin
                    victim_d = victim;
                    state_d  = (bus.way_valid[victim] && bus.way_dirty[victim]) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                bus.pmem_write    = 1'b1;
                bus.pmem_addr_sel = 1'b1;
                bus.way_sel       = victim_q;
                state_d           = bus.pmem_resp ? FETCH : WRITEBACK;
            end
            FETCH: begin
                bus.pmem_read = 1'b1;
                bus.way_sel   = victim_q;
                bus.load_line = bus.pmem_resp;
                state_d       = bus.pmem_resp ? IDLE : FETCH;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/assoc_cache_control.md
# assoc_cache_control

Control FSM for the 4-way set-associative cache. It sits directly upstream of `lru_stack`: it consumes the stack's `lru` output to choose a victim way on a miss, and drives the stack's `write`/`index` inputs to promote the accessed way to MRU on every completed access. It sequences hit service, dirty-victim writeback and line fill against physical memory, and drives select/load strobes into the cache datapath.

## Interface
Parameters:
- None. Way count is fixed at 4 with a 2-bit way encoding (`lc3b_way`).

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_read` in 1: CPU read request, held until `mem_resp`.
- `mem_write` in 1: CPU write request, held until `mem_resp`. Takes precedence if asserted together with `mem_read`.
- `mem_resp` out 1: CPU access complete.
- `way_hit` in 4: per-way tag match AND valid, from datapath.
- `way_valid` in 4: per-way valid bits of the addressed set.
- `way_dirty` in 4: per-way dirty bits of the addressed set.
- `lru` in 2: LRU way of the addressed set, from `lru_stack`.
- `lru_write` out 1: to `lru_stack` `write`; promote `lru_index` to MRU.
- `lru_index` out 2: to `lru_stack` `index`.
- `way_sel` out 2: datapath way mux select.
- `load_word` out 1: merge CPU write data into `way_sel` and set its dirty bit.
- `load_line` out 1: load pmem line into `way_sel`; set valid, write tag, clear dirty.
- `pmem_addr_sel` out 1: 0 = CPU address; 1 = victim tag/set address (writeback).
- `pmem_read` out 1 / `pmem_write` out 1: physical memory requests.
- `pmem_resp` in 1: physical memory transfer complete.

## Operation
- States: IDLE, WRITEBACK, FETCH. Registers are `state` and `victim_q` (2 bits) only.
- Request is `mem_read | mem_write`. Hit way is the lowest-index set bit of `way_hit`; multiple hits resolve to the lowest index.
- IDLE, request with hit: `mem_resp=1`, `lru_write=1`, `lru_index=way_sel=hit way`, `load_word=mem_write`. Stay in IDLE.
- IDLE, request with miss: `victim_q <=` lowest-index invalid way if any `way_valid` bit is 0, else `lru`.
  - If the chosen victim is valid and dirty, go to WRITEBACK; otherwise go to FETCH.
  - No `mem_resp` and no LRU update in this cycle.
- WRITEBACK: `pmem_write=1`, `pmem_addr_sel=1`, `way_sel=victim_q`. On `pmem_resp`, go to FETCH.
- FETCH: `pmem_read=1`, `pmem_addr_sel=0`, `way_sel=victim_q`. On `pmem_resp`: `load_line=1`, go to IDLE. The re-presented request then hits, which updates the LRU exactly once per access.
- Request dropped mid-miss (CPU protocol violation): the pmem transfer in flight completes and the fill still happens; no `mem_resp` is issued.
- Reset asserted in any state: immediately `state=IDLE`, `victim_q=0`; `pmem_read`/`pmem_write` drop asynchronously. `lru_stack` contents are untouched.

## Timing
- Reset values: all outputs 0; `way_sel`/`lru_index` = 0.
- IDLE outputs are Mealy (combinational from request and hit inputs). WRITEBACK/FETCH outputs are Moore, except `load_line`, which is gated by `pmem_resp`.
- Hit latency: `mem_resp` in the same cycle the request is presented.
- Clean miss, request at cycle 0:
  - `pmem_read` high from cycle 1 through the `pmem_resp` cycle N, with `load_line` at N.
  - `mem_resp` at N+1.
- Dirty miss: the WRITEBACK span (1 cycle through first `pmem_resp`) precedes FETCH. `mem_resp` comes 1 cycle after the fill `pmem_resp`.
- `pmem_read` and `pmem_write` are never asserted together.
- `pmem_resp` in IDLE is ignored.

## Structure
- `lc3b_types` adds `lc3b_way` (logic [1:0]) and `lc3b_way_mask` (logic [3:0]). The state enum stays local.
- One combinational sub-module `way_select`:
  - hit mask → (hit flag, hit way) priority encoder;
  - valid mask + `lru` → victim way.

## Test plan
- Read hit, `way_hit=4'b0100` → same-cycle `mem_resp=1`, `lru_write=1`, `lru_index=2`, `load_word=0`.
- Write hit, `way_hit=4'b1001` → `lru_index=0`, `way_sel=0`, `load_word=1`.
- Miss, `way_valid=4'b1011`, `lru=0` → victim 2, FETCH. `pmem_resp` after 5 cycles → `load_line` with `way_sel=2`. Then a hit updates LRU to 2.
- Miss, all valid, `lru=3`, `way_dirty=4'b1000` → WRITEBACK with `pmem_addr_sel=1`, then FETCH, then `mem_resp`. `pmem_read`/`pmem_write` never overlap.
- `rst_n` low during WRITEBACK → `pmem_write` drops within the same cycle, state IDLE. A subsequent request behaves as fresh.
- `mem_read` and `mem_write` both high on a hit → treated as write (`load_word=1`).
